// File: rtl/tc_out_drain.sv
// Tensor-core output drain: accumulates K-chunk partial-sum tiles
// and streams each finished tile out one row per beat.
module tc_out_drain #(
    parameter int TILE_M = 4,
    parameter int TILE_N = 4,
    parameter int DW_OUT = 32,
    localparam int RW = (TILE_M > 1) ? $clog2(TILE_M) : 1,
    localparam int TW = TILE_M * TILE_N * DW_OUT,
    localparam int OW = TILE_N * DW_OUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [TW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [RW-1:0] out_row,
    output logic          out_last,
    output logic [15:0]   tile_cnt
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(TILE_M - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] acc_q, acc_d;
    logic [TW-1:0] buf_q, buf_d;
    logic          hold_q, hold_d;
    logic [RW-1:0] row_q, row_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [TW-1:0] sum;
    logic          in_fire;
    logic          out_fire;
    logic          final_fire;
    logic          can_load;

    assign in_ready   = ~hold_q;
    assign out_valid  = (state_q == DRAIN);
    assign out_row    = row_q;
    assign out_last   = out_valid & (row_q == LAST_ROW);
    assign tile_cnt   = cnt_q;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign final_fire = out_fire & (row_q == LAST_ROW);
    assign can_load   = (state_q == IDLE) | final_fire;

    // Element-wise add; each slice wraps modulo 2^DW_OUT.
    always_comb begin
        sum = '0;
        for (int e = 0; e < TILE_M * TILE_N; e++) begin
            sum[e*DW_OUT +: DW_OUT] =
                acc_q[e*DW_OUT +: DW_OUT] +
                in_data[e*DW_OUT +: DW_OUT];
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            for (int r = 0; r < TILE_M; r++) begin
                if (row_q == RW'(r)) begin
                    out_data = buf_q[r*OW +: OW];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        buf_d   = buf_q;
        hold_d  = hold_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        if (final_fire) begin
            cnt_d   = cnt_q + 16'd1;
            row_d   = '0;
            state_d = IDLE;
        end else if (out_fire) begin
            row_d = row_q + RW'(1);
        end
        // A held tile takes priority; in_ready is low then.
        if (final_fire && hold_q) begin
            buf_d   = acc_q;
            acc_d   = '0;
            hold_d  = 1'b0;
            state_d = DRAIN;
        end
        if (in_fire) begin
            if (!in_last) begin
                acc_d = sum;
            end else if (can_load) begin
                buf_d   = sum;
                acc_d   = '0;
                row_d   = '0;
                state_d = DRAIN;
            end else begin
                acc_d  = sum;
                hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            buf_q   <= '0;
            hold_q  <= 1'b0;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            buf_q   <= buf_d;
            hold_q  <= hold_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tc_out_drain.sv
// Scoreboard bench for tc_out_drain: directed tiles, rows checked
// by an independent monitor against hand-computed expectations.
module tb_tc_out_drain;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   out_row;
    logic         out_last;
    logic [15:0]  tile_cnt;

    typedef struct packed {
        logic         last;
        logic [1:0]   row;
        logic [127:0] data;
    } row_t;

    row_t sb[$];
    int   vecs;
    int   errs;

    tc_out_drain dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_last (out_last),
        .tile_cnt (tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] uni(input logic [31:0] v);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = v;
        return d;
    endfunction

    function automatic logic [127:0] urow(input logic [31:0] v);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = v;
        return d;
    endfunction

    task automatic push_uni(input logic [31:0] v);
        row_t e;
        for (int r = 0; r < 4; r++) begin
            e.last = (r == 3);
            e.row  = 2'(r);
            e.data = urow(v);
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            vecs++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_row: got row %0d data %0h want none",
                         out_row, out_data);
            end else begin
                row_t e;
                e = sb.pop_front();
                if ({out_last, out_row, out_data} !== e) begin
                    errs++;
                    $display("FAIL row: got %0b/%0d/%0h want %0b/%0d/%0h",
                             out_last, out_row, out_data,
                             e.last, e.row, e.data);
                end
            end
        end
    end

    // Caller sits at posedge+1; returns at posedge+1 after acceptance.
    task automatic beat(input logic [511:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [511:0] md;
        row_t e;
        vecs      = 0;
        errs      = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step(2);
        chk("rst_out_valid", 128'(out_valid), 0);
        chk("rst_in_ready", 128'(in_ready), 1);
        chk("rst_tile_cnt", 128'(tile_cnt), 0);
        chk("rst_out_row", 128'(out_row), 0);
        chk("rst_out_last", 128'(out_last), 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        step(1);

        // 1: 5 + 7 = 12, four consecutive rows
        beat(uni(32'd5), 1'b0);
        push_uni(32'd12);
        beat(uni(32'd7), 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 128'(out_valid), 1);
            chk("t1_row", 128'(out_row), 128'(i));
            step(1);
        end
        chk("t1_idle", 128'(out_valid), 0);
        chk("t1_cnt", 128'(tile_cnt), 1);

        // 2: modular wrap
        beat(uni(32'h7FFF_FFFF), 1'b0);
        push_uni(32'h8000_0001);
        beat(uni(32'h0000_0002), 1'b1);
        beat(uni(32'hFFFF_FFFF), 1'b0);
        push_uni(32'hFFFF_FFFE);
        beat(uni(32'hFFFF_FFFF), 1'b1);
        wait_idle();
        chk("t2_cnt", 128'(tile_cnt), 3);

        // 3: backpressure with a held tile
        out_ready = 1'b0;
        push_uni(32'd1);
        beat(uni(32'd1), 1'b1);
        beat(uni(32'd2), 1'b0);
        push_uni(32'd5);
        beat(uni(32'd3), 1'b1);
        chk("t3_hold_in_ready", 128'(in_ready), 0);
        chk("t3_row0", 128'(out_row), 0);
        chk("t3_data0", out_data, urow(32'd1));
        step(3);
        chk("t3_in_ready_stall", 128'(in_ready), 0);
        chk("t3_row0_stable", 128'(out_row), 0);
        chk("t3_data0_stable", out_data, urow(32'd1));
        chk("t3_valid_stable", 128'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid", 128'(out_valid), 1);
            if (i == 0) chk("t3_in_ready_a", 128'(in_ready), 0);
            if (i == 4) chk("t3_in_ready_b", 128'(in_ready), 1);
            step(1);
        end
        chk("t3_idle", 128'(out_valid), 0);
        chk("t3_cnt", 128'(tile_cnt), 5);

        // 4: B's last beat meets A's final row handshake
        push_uni(32'd4);
        beat(uni(32'd4), 1'b1);
        step(2);
        beat(uni(32'd1), 1'b0);
        chk("t4_row3", 128'(out_row), 3);
        push_uni(32'd9);
        beat(uni(32'd8), 1'b1);
        chk("t4_no_bubble", 128'(out_valid), 1);
        chk("t4_b_row0", 128'(out_row), 0);
        chk("t4_b_data", out_data, urow(32'd9));
        chk("t4_no_hold", 128'(in_ready), 1);
        wait_idle();
        chk("t4_cnt", 128'(tile_cnt), 7);

        // 5: reset at row 2 discards the tile
        push_uni(32'd6);
        beat(uni(32'd6), 1'b1);
        step(2);
        chk("t5_row2", 128'(out_row), 2);
        reset = 1'b1;
        void'(sb.pop_back());
        void'(sb.pop_back());
        #1;
        chk("t5_valid_async", 128'(out_valid), 0);
        chk("t5_cnt_async", 128'(tile_cnt), 0);
        step(1);
        reset = 1'b0;
        chk("t5_post_valid", 128'(out_valid), 0);
        chk("t5_post_row", 128'(out_row), 0);
        push_uni(32'd3);
        beat(uni(32'd3), 1'b1);
        wait_idle();
        chk("t5_cnt", 128'(tile_cnt), 1);

        // 6: element (m,n) = 16*m+n maps to row m lane n
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                md[(m*4+n)*32 +: 32] = 32'(16*m + n);
                e.data[n*32 +: 32]   = 32'(16*m + n);
            end
            e.row  = 2'(m);
            e.last = (m == 3);
            sb.push_back(e);
        end
        beat(md, 1'b1);
        wait_idle();
        chk("t6_cnt", 128'(tile_cnt), 2);
        chk("sb_empty", 128'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
